// File: rtl/dmem_arb.sv
// dmem_arb: shares data-memory port 0 between the MA/MO pipeline stages and
// the loader/debug engine. The pipeline wins by default; a saturating
// starvation counter forces a loader grant, and a lock FSM lets the loader
// keep the port for a burst. Pipeline grant loss is raised as a stall.

`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dmem_arb #(
    parameter int ADDR_W     = `SIZE_ADDR,
    parameter int DATA_W     = `SIZE_DATA,
    parameter int STARVE_MAX = 8
) (
    input  logic              iw_clk,
    input  logic              iw_rst_n,
    input  logic              iw_p_req,
    input  logic              iw_p_we,
    input  logic [ADDR_W-1:0] iw_p_addr,
    input  logic [DATA_W-1:0] iw_p_wdata,
    output logic              ow_p_gnt,
    output logic              ow_p_rvalid,
    output logic [DATA_W-1:0] ow_p_rdata,
    output logic              ow_stall,
    input  logic              iw_l_req,
    input  logic              iw_l_we,
    input  logic              iw_l_lock,
    input  logic [ADDR_W-1:0] iw_l_addr,
    input  logic [DATA_W-1:0] iw_l_wdata,
    output logic              ow_l_gnt,
    output logic              ow_l_rvalid,
    output logic [DATA_W-1:0] ow_l_rdata,
    output logic              ow_mem_we,
    output logic [ADDR_W-1:0] ow_mem_addr,
    output logic [DATA_W-1:0] ow_mem_wdata,
    input  logic [DATA_W-1:0] iw_mem_rdata
);

    typedef enum logic {
        ST_PIPE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [7:0] LP_STARVE_MAX = 8'(STARVE_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_starve;
    logic       r_p_rd;
    logic       r_l_rd;
    logic       w_p_gnt;
    logic       w_l_gnt;

    // Lock FSM state register; reset always returns ownership to the pipeline.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_state <= ST_PIPE;
        end else begin
            r_state <= w_next;
        end
    end

    // Grant decision and next state; lock release takes effect at the edge
    // after a lock-low cycle, and that cycle's loader grant is still issued.
    always_comb begin
        w_p_gnt = 1'b0;
        w_l_gnt = 1'b0;
        w_next  = r_state;
        if (r_state == ST_PIPE) begin
            if ((r_starve == LP_STARVE_MAX) && iw_l_req) begin
                w_l_gnt = 1'b1;
            end else if (iw_p_req) begin
                w_p_gnt = 1'b1;
            end else if (iw_l_req) begin
                w_l_gnt = 1'b1;
            end
            if (w_l_gnt && iw_l_lock) begin
                w_next = ST_LOAD;
            end
        end else begin
            w_l_gnt = iw_l_req;
            if (!iw_l_lock) begin
                w_next = ST_PIPE;
            end
        end
    end

    // Starvation counter: counts consecutive denied loader cycles, saturating.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_starve <= 8'd0;
        end else if (w_l_gnt || !iw_l_req) begin
            r_starve <= 8'd0;
        end else if (r_starve != LP_STARVE_MAX) begin
            r_starve <= r_starve + 8'd1;
        end
    end

    // Read-return tracking: remembers which requester issued a read last cycle.
    always_ff @(posedge iw_clk or negedge iw_rst_n) begin
        if (!iw_rst_n) begin
            r_p_rd <= 1'b0;
            r_l_rd <= 1'b0;
        end else begin
            r_p_rd <= w_p_gnt && !iw_p_we;
            r_l_rd <= w_l_gnt && !iw_l_we;
        end
    end

    // Memory port mux; the bus is driven to zero when nobody is granted.
    always_comb begin
        ow_mem_we    = 1'b0;
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        if (w_p_gnt) begin
            ow_mem_we    = iw_p_we;
            ow_mem_addr  = iw_p_addr;
            ow_mem_wdata = iw_p_wdata;
        end else if (w_l_gnt) begin
            ow_mem_we    = iw_l_we;
            ow_mem_addr  = iw_l_addr;
            ow_mem_wdata = iw_l_wdata;
        end
    end

    assign ow_p_gnt    = w_p_gnt;
    assign ow_l_gnt    = w_l_gnt;
    assign ow_stall    = iw_p_req && !w_p_gnt;
    assign ow_p_rvalid = r_p_rd;
    assign ow_l_rvalid = r_l_rd;
    assign ow_p_rdata  = r_p_rd ? iw_mem_rdata : '0;
    assign ow_l_rdata  = r_l_rd ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed bench for dmem_arb with a small synchronous memory
// model on the memory port. Inputs change 1 ns after the rising edge and
// outputs are checked mid-cycle.

`timescale 1ns/1ps

module tb_dmem_arb;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p_req, p_we, l_req, l_we, l_lock;
    logic [AW-1:0] p_addr, l_addr;
    logic [DW-1:0] p_wdata, l_wdata;
    logic          p_gnt, p_rvalid, stall, l_gnt, l_rvalid, mem_we;
    logic [DW-1:0] p_rdata, l_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(4)) dut (
        .iw_clk(clk), .iw_rst_n(rst_n),
        .iw_p_req(p_req), .iw_p_we(p_we), .iw_p_addr(p_addr), .iw_p_wdata(p_wdata),
        .ow_p_gnt(p_gnt), .ow_p_rvalid(p_rvalid), .ow_p_rdata(p_rdata), .ow_stall(stall),
        .iw_l_req(l_req), .iw_l_we(l_we), .iw_l_lock(l_lock), .iw_l_addr(l_addr),
        .iw_l_wdata(l_wdata), .ow_l_gnt(l_gnt), .ow_l_rvalid(l_rvalid), .ow_l_rdata(l_rdata),
        .ow_mem_we(mem_we), .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
        .iw_mem_rdata(mem_rdata)
    );

    // Synchronous memory: write commits at the edge, read data one cycle later.
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic drv_p(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req = req; p_we = we; p_addr = a; p_wdata = d;
    endtask

    task automatic drv_l(input logic req, input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        l_req = req; l_we = we; l_lock = lk; l_addr = a; l_wdata = d;
    endtask

    task automatic idle();
        drv_p(1'b0, 1'b0, '0, '0);
        drv_l(1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        rst_n = 1'b0;
        idle();
        #3;
        chk("rst_p_gnt", 32'(p_gnt), 0);
        chk("rst_l_gnt", 32'(l_gnt), 0);
        chk("rst_p_rvalid", 32'(p_rvalid), 0);
        chk("rst_l_rdata", l_rdata, 0);
        #9 rst_n = 1'b1;
        step();

        // Pipeline only: write then read back
        drv_p(1'b1, 1'b1, 16'h10, 32'h1234);
        #3;
        chk("po_wr_gnt", 32'(p_gnt), 1);
        chk("po_wr_stall", 32'(stall), 0);
        chk("po_wr_mem_we", 32'(mem_we), 1);
        chk("po_wr_mem_addr", 32'(mem_addr), 32'h10);
        chk("po_wr_mem_wdata", mem_wdata, 32'h1234);
        step();
        drv_p(1'b1, 1'b0, 16'h10, 32'h0);
        #3;
        chk("po_rd_gnt", 32'(p_gnt), 1);
        chk("po_rd_stall", 32'(stall), 0);
        chk("po_rd_mem_we", 32'(mem_we), 0);
        chk("po_wr_no_rvalid", 32'(p_rvalid), 0);
        step();
        // preload 0x20..0x23 with 0xA0..0xA3 while checking the read return
        for (int i = 0; i < 4; i++) begin
            drv_p(1'b1, 1'b1, 16'(32'h20 + i), 32'(32'hA0 + i));
            #3;
            if (i == 0) begin
                chk("po_rvalid", 32'(p_rvalid), 1);
                chk("po_rdata", p_rdata, 32'h1234);
            end
            step();
        end
        idle();
        #3;
        chk("po_rvalid_drop", 32'(p_rvalid), 0);
        chk("po_rdata_zero", p_rdata, 0);
        step();

        // Contention with starvation limit 4
        drv_p(1'b1, 1'b1, 16'h40, 32'h55);
        drv_l(1'b1, 1'b0, 1'b0, 16'h10, 32'h0);
        for (int i = 0; i < 10; i++) begin
            #3;
            chk($sformatf("ctn_p_gnt%0d", i), 32'(p_gnt), 32'(i % 5 != 4));
            chk($sformatf("ctn_l_gnt%0d", i), 32'(l_gnt), 32'(i % 5 == 4));
            chk($sformatf("ctn_stall%0d", i), 32'(stall), 32'(i % 5 == 4));
            if (i == 5) begin
                chk("ctn_l_rvalid", 32'(l_rvalid), 1);
                chk("ctn_l_rdata", l_rdata, 32'h1234);
            end
            step();
        end
        idle();
        step();

        // Locked burst 0x20..0x23 with the pipeline requesting throughout
        k = 0;
        for (int c = 0; c < 9; c++) begin
            drv_p(1'b1, 1'b1, 16'h41, 32'h66);
            drv_l(k < 4, 1'b0, k < 3, 16'(32'h20 + k), 32'h0);
            #3;
            chk($sformatf("bst_l_gnt%0d", c), 32'(l_gnt), 32'(c >= 4 && c <= 7));
            chk($sformatf("bst_p_gnt%0d", c), 32'(p_gnt), 32'(c < 4 || c == 8));
            chk($sformatf("bst_stall%0d", c), 32'(stall), 32'(c >= 4 && c <= 7));
            if (c >= 5) begin
                chk($sformatf("bst_l_rvalid%0d", c), 32'(l_rvalid), 1);
                chk($sformatf("bst_l_rdata%0d", c), l_rdata, 32'(32'hA0 + c - 5));
            end
            if (l_gnt) k++;
            step();
        end
        idle();
        step();

        // Reset during a locked burst with a loader read outstanding
        drv_l(1'b1, 1'b0, 1'b1, 16'h21, 32'h0);
        #3;
        chk("rb_l_gnt", 32'(l_gnt), 1);
        step();
        drv_p(1'b1, 1'b1, 16'h42, 32'h77);
        #3;
        chk("rb_locked_p_gnt", 32'(p_gnt), 0);
        chk("rb_locked_stall", 32'(stall), 1);
        chk("rb_l_rvalid_pre", 32'(l_rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("rb_l_rvalid_rst", 32'(l_rvalid), 0);
        chk("rb_l_rdata_rst", l_rdata, 0);
        chk("rb_p_gnt_rst", 32'(p_gnt), 1);
        chk("rb_l_gnt_rst", 32'(l_gnt), 0);
        #1 rst_n = 1'b1;
        step();
        #3;
        chk("rb_after_p_gnt", 32'(p_gnt), 1);
        chk("rb_after_l_rvalid", 32'(l_rvalid), 0);
        idle();
        step();

        // Pipeline read outstanding when reset hits
        drv_p(1'b1, 1'b0, 16'h10, 32'h0);
        step();
        idle();
        #2;
        chk("rr_p_rvalid_pre", 32'(p_rvalid), 1);
        rst_n = 1'b0;
        #1;
        chk("rr_p_rvalid_rst", 32'(p_rvalid), 0);
        chk("rr_p_rdata_rst", p_rdata, 0);
        #1 rst_n = 1'b1;
        step();

        // Cross-requester coherence: loader write then pipeline read
        drv_l(1'b1, 1'b1, 1'b0, 16'h05, 32'hABC);
        #3;
        chk("coh_l_gnt", 32'(l_gnt), 1);
        step();
        idle();
        drv_p(1'b1, 1'b0, 16'h05, 32'h0);
        #3;
        chk("coh_p_gnt", 32'(p_gnt), 1);
        chk("coh_l_rvalid1", 32'(l_rvalid), 0);
        step();
        idle();
        #3;
        chk("coh_p_rvalid", 32'(p_rvalid), 1);
        chk("coh_p_rdata", p_rdata, 32'hABC);
        chk("coh_l_rvalid2", 32'(l_rvalid), 0);
        step();

        // Idle: quiet bus, and the starvation counter stays clear
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("idl_mem_we%0d", i), 32'(mem_we), 0);
            chk($sformatf("idl_mem_addr%0d", i), 32'(mem_addr), 0);
            chk($sformatf("idl_mem_wdata%0d", i), mem_wdata, 0);
            chk($sformatf("idl_gnts%0d", i), 32'({p_gnt, l_gnt, stall}), 0);
            step();
        end
        drv_p(1'b1, 1'b1, 16'h43, 32'h1);
        drv_l(1'b1, 1'b0, 1'b0, 16'h10, 32'h0);
        #3;
        chk("idl_starve_p_gnt", 32'(p_gnt), 1);
        chk("idl_starve_l_gnt", 32'(l_gnt), 0);
        step();
        idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
